// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch unit:
//            fetch FSM state encoding, the {pc, inst} buffer entry and the
//            instruction word size in bytes.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small circular buffer of fetched {pc, inst} entries.
// Ports    : clk       in   clock
//            rst       in   synchronous active-high reset
//            flush     in   empty the buffer; overrides push and pop
//            push      in   write push_data at the tail
//            push_data in   entry to write
//            pop       in   drop the head entry
//            head      out  entry at the head of the buffer
//            count     out  number of valid entries
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic w_push;
    logic w_pop;

    // A flush cycle must not leave a half-applied push or pop behind.
    assign w_push = push & ~flush;
    assign w_pop  = pop  & ~flush;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module   : inst_fetch_unit
// Purpose  : Consumer end of the PC interface. Issues one instruction-memory
//            read per PC address (req/gnt + rvalid), stalls the PC until a
//            request is granted, buffers {pc, inst} pairs for decode and
//            flushes/discards on branch redirects.
// Ports    : clk, rst                      clock, sync active-high reset
//            pc_address, is_branch_taken   from the PC
//            pc_stall                      to the PC
//            imem_req/addr/gnt/rvalid/rdata instruction memory port
//            inst_valid/ready, inst, inst_pc decode interface
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_address,
    input  logic        is_branch_taken,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int                 c_CNT_W   = $clog2(DEPTH+1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam int                 c_ALIGN_W = $clog2(WORD_BYTES);

    fetch_state_t       r_state;
    logic [31:0]        r_req_pc;

    logic [c_CNT_W-1:0] w_count;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_data;
    logic               w_push;
    logic               w_pop;
    logic               w_room;

    // Requests are only issued with buffer room, so a response always has a
    // slot waiting for it. During a redirect pc_address is stale: no request.
    assign w_room    = (w_count < c_FULL);
    assign imem_req  = (r_state == S_REQ) & w_room & ~is_branch_taken & ~rst;
    assign imem_addr = pc_address;

    // The PC honours stall over branch, so stall must be released whenever a
    // redirect is presented or the new target would never be loaded.
    assign pc_stall  = ~(imem_req & imem_gnt) & ~is_branch_taken;

    assign inst_valid  = (w_count != '0) & ~is_branch_taken;
    assign w_pop       = inst_valid & inst_ready;
    assign w_push      = (r_state == S_WAIT) & imem_rvalid & ~is_branch_taken;
    assign w_push_data = {r_req_pc, imem_rdata};

    assign inst    = w_head.inst;
    assign inst_pc = w_head.pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (is_branch_taken),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_REQ;
            r_req_pc <= '0;
        end else if (is_branch_taken) begin
            // An outstanding response still has to come back; S_DROP swallows it.
            case (r_state)
                S_WAIT:  r_state <= imem_rvalid ? S_REQ : S_DROP;
                S_DROP:  r_state <= imem_rvalid ? S_REQ : S_DROP;
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_req && imem_gnt) begin
                        r_req_pc <= pc_address;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    a_addr_aligned : assert property (@(posedge clk) disable iff (rst)
        imem_req |-> (imem_addr[c_ALIGN_W-1:0] == '0));

    a_rvalid_outstanding : assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (r_state != S_REQ));

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        (w_push && (w_count == c_FULL)) |-> w_pop);

    a_reset_pc : assert property (@(posedge clk)
        ($past(rst) && !rst && imem_req) |-> (imem_addr == RESET_PC));

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// Module   : tb_inst_fetch_unit
// Purpose  : Self-checking bench for inst_fetch_unit. The bench acts as the
//            PC and the instruction memory; expected {pc, inst} pairs are
//            queued at grant and compared when decode pops them.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_inst_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_address;
    logic        is_branch_taken;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Bench-side PC, memory and expected-buffer state.
    logic [31:0]  m_pc;
    logic [31:0]  m_pend_pc;
    bit           m_pend;
    bit           m_stale;
    fetch_entry_t m_q[$];
    logic [31:0]  pop_pcs[$];
    int           pop_cyc[$];

    logic        last_req;
    logic        last_stall;
    logic        last_valid;
    logic [31:0] last_addr;

    inst_fetch_unit #(
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_address      (pc_address),
        .is_branch_taken (is_branch_taken),
        .pc_stall        (pc_stall),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive inputs, sample and score outputs, advance the models.
    task automatic cycle(input bit br, input logic [31:0] tgt, input bit rdy,
                         input bit gnt, input bit allow_rv);
        bit rv, exp_req, exp_valid, exp_stall;
        fetch_entry_t e;
        rv = m_pend && allow_rv;
        pc_address      = m_pc;
        is_branch_taken = br;
        inst_ready      = rdy;
        imem_gnt        = gnt;
        imem_rvalid     = rv;
        imem_rdata      = rv ? (32'h2000_0000 + m_pend_pc) : 32'hDEAD_BEEF;
        #1;
        exp_req   = !m_pend && (m_q.size() < 2) && !br;
        exp_valid = (m_q.size() != 0) && !br;
        exp_stall = !(exp_req && gnt) && !br;
        last_req = imem_req; last_stall = pc_stall;
        last_valid = inst_valid; last_addr = imem_addr;
        n_checks++;
        if (imem_req !== exp_req) begin
            n_fail++; $display("FAIL imem_req cyc %0d: got %b expected %b", cyc, imem_req, exp_req);
        end
        n_checks++;
        if (pc_stall !== exp_stall) begin
            n_fail++; $display("FAIL pc_stall cyc %0d: got %b expected %b", cyc, pc_stall, exp_stall);
        end
        n_checks++;
        if (inst_valid !== exp_valid) begin
            n_fail++; $display("FAIL inst_valid cyc %0d: got %b expected %b", cyc, inst_valid, exp_valid);
        end
        if (exp_req) begin
            n_checks++;
            if (imem_addr !== m_pc) begin
                n_fail++; $display("FAIL imem_addr cyc %0d: got %h expected %h", cyc, imem_addr, m_pc);
            end
        end
        if (exp_valid && rdy) begin
            e = m_q.pop_front();
            n_checks++;
            if (inst_pc !== e.pc) begin
                n_fail++; $display("FAIL inst_pc cyc %0d: got %h expected %h", cyc, inst_pc, e.pc);
            end
            n_checks++;
            if (inst !== e.inst) begin
                n_fail++; $display("FAIL inst cyc %0d: got %h expected %h", cyc, inst, e.inst);
            end
            pop_pcs.push_back(e.pc);
            pop_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (br) begin
            m_q.delete();
            if (m_pend) begin
                if (rv) begin m_pend = 0; m_stale = 0; end
                else    m_stale = 1;
            end
            m_pc = tgt;
        end else begin
            if (rv) begin
                if (!m_stale) m_q.push_back({m_pend_pc, 32'h2000_0000 + m_pend_pc});
                m_pend = 0; m_stale = 0;
            end
            if (exp_req && gnt) begin
                m_pend = 1; m_stale = 0; m_pend_pc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pc_address = '0; is_branch_taken = 1'b0; inst_ready = 1'b0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (3) begin
            #1;
            n_checks++;
            if (imem_req !== 1'b0) begin
                n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req);
            end
            n_checks++;
            if (pc_stall !== 1'b1) begin
                n_fail++; $display("FAIL reset_stall: got %b expected 1", pc_stall);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        m_pc = '0; m_pend = 0; m_stale = 0;
        m_q.delete(); pop_pcs.delete(); pop_cyc.delete();
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid);
        end
        n_checks++;
        if (dut.u_fifo.count !== 2'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", dut.u_fifo.count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        cycle(0, 0, 1, 1, 1);
        n_checks++;
        if (last_req !== 1'b1 || last_addr !== 32'h0 || last_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL first_req: got req=%b addr=%h stall=%b expected req=1 addr=0 stall=0",
                     last_req, last_addr, last_stall);
        end
    endtask

    task automatic test_throughput();
        do_reset();
        repeat (7) cycle(0, 0, 1, 1, 1);
        n_checks++;
        if (pop_pcs.size() != 3) begin
            n_fail++; $display("FAIL tput_count: got %0d pops expected 3", pop_pcs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (pop_pcs[i] !== 32'(4 * i)) begin
                    n_fail++; $display("FAIL tput_pc[%0d]: got %h expected %h", i, pop_pcs[i], 32'(4 * i));
                end
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (pop_cyc[i+1] - pop_cyc[i] != 2) begin
                    n_fail++; $display("FAIL tput_gap[%0d]: got %0d expected 2", i, pop_cyc[i+1] - pop_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        repeat (8) cycle(0, 0, 0, 1, 1);
        imem_rvalid = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || pc_stall !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold: got req=%b stall=%b expected req=0 stall=1", imem_req, pc_stall);
        end
        n_checks++;
        if (dut.u_fifo.count !== 2'd2) begin
            n_fail++; $display("FAIL bp_count: got %0d expected 2", dut.u_fifo.count);
        end
        pop_pcs.delete();
        repeat (8) cycle(0, 0, 1, 1, 1);
        n_checks++;
        if (pop_pcs.size() < 3 || pop_pcs[0] !== 32'h0C) begin
            n_fail++; $display("FAIL bp_first: got %0d pops expected >=3 starting at 0c", pop_pcs.size());
        end else begin
            for (int i = 1; i < pop_pcs.size(); i++) begin
                n_checks++;
                if (pop_pcs[i] !== pop_pcs[i-1] + 32'd4) begin
                    n_fail++; $display("FAIL bp_seq[%0d]: got %h expected %h", i, pop_pcs[i], pop_pcs[i-1] + 32'd4);
                end
            end
        end
    endtask

    task automatic test_branch_wait();
        do_reset();
        repeat (5) cycle(0, 0, 1, 1, 1);
        cycle(1, 32'h100, 1, 1, 0);
        n_checks++;
        if (last_stall !== 1'b0 || last_valid !== 1'b0) begin
            n_fail++; $display("FAIL brw_outs: got stall=%b valid=%b expected 0 0", last_stall, last_valid);
        end
        n_checks++;
        if (dut.u_fifo.count !== 2'd0) begin
            n_fail++; $display("FAIL brw_count: got %0d expected 0", dut.u_fifo.count);
        end
        n_checks++;
        if (dut.r_state !== S_DROP) begin
            n_fail++; $display("FAIL brw_state: got %0d expected %0d", dut.r_state, S_DROP);
        end
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 1);
        pop_pcs.delete();
        repeat (6) cycle(0, 0, 1, 1, 1);
        n_checks++;
        if (pop_pcs.size() == 0 || pop_pcs[0] !== 32'h100) begin
            n_fail++; $display("FAIL brw_next: got %0d pops expected first pc 100", pop_pcs.size());
        end
    endtask

    task automatic test_branch_rvalid();
        for (int i = 0; i < 10 && !m_pend; i++) cycle(0, 0, 1, 1, 0);
        n_checks++;
        if (!m_pend) begin
            n_fail++; $display("FAIL brr_timeout: got no grant expected one within 10 cycles");
        end
        cycle(1, 32'h200, 1, 1, 1);
        n_checks++;
        if (last_req !== 1'b0) begin
            n_fail++; $display("FAIL brr_req: got %b expected 0", last_req);
        end
        n_checks++;
        if (dut.r_state !== S_REQ) begin
            n_fail++; $display("FAIL brr_state: got %0d expected %0d", dut.r_state, S_REQ);
        end
        cycle(0, 0, 1, 1, 1);
        n_checks++;
        if (last_req !== 1'b1 || last_addr !== 32'h200) begin
            n_fail++; $display("FAIL brr_next: got req=%b addr=%h expected req=1 addr=200", last_req, last_addr);
        end
    endtask

    task automatic test_branch_pop();
        repeat (8) cycle(0, 0, 0, 1, 1);
        cycle(1, 32'h300, 1, 1, 1);
        n_checks++;
        if (last_valid !== 1'b0) begin
            n_fail++; $display("FAIL brp_valid: got %b expected 0", last_valid);
        end
        n_checks++;
        if (dut.u_fifo.count !== 2'd0) begin
            n_fail++; $display("FAIL brp_count: got %0d expected 0", dut.u_fifo.count);
        end
        pop_pcs.delete();
        repeat (6) cycle(0, 0, 1, 1, 1);
        n_checks++;
        if (pop_pcs.size() == 0 || pop_pcs[0] !== 32'h300) begin
            n_fail++; $display("FAIL brp_next: got %0d pops expected first pc 300", pop_pcs.size());
        end
    endtask

    task automatic test_random();
        int pops_before;
        pops_before = pop_pcs.size();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 19) == 0, 32'($urandom_range(0, 1023)) << 2,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) != 0);
        end
        repeat (20) cycle(0, 0, 1, 1, 1);
        n_checks++;
        if (pop_pcs.size() <= pops_before) begin
            n_fail++; $display("FAIL rand_progress: got %0d pops expected more than %0d", pop_pcs.size(), pops_before);
        end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_backpressure();
        test_branch_wait();
        test_branch_rvalid();
        test_branch_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
